// File: rtl/card_dealer.sv
// Serial card collector for a 9-player hold'em deal: gathers 21 cards, rejects
// illegal ranks and duplicates, and emits one packed deal frame or an error pulse.
module card_dealer (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        in_valid,
  input  logic [3:0]  in_num,
  input  logic [1:0]  in_suit,
  output logic        in_ready,
  output logic        out_valid,
  output logic [71:0] out_hole_num,
  output logic [35:0] out_hole_suit,
  output logic [11:0] out_pub_num,
  output logic [5:0]  out_pub_suit,
  output logic        out_err
);

  typedef enum logic [1:0] {
    IDLE,
    LOAD,
    SEND
  } state_t;

  localparam logic [4:0] LAST_IDX = 5'd20;

  state_t      state;
  logic [4:0]  idx;
  logic [51:0] mask;
  logic        bad;
  logic [83:0] frame_num;
  logic [41:0] frame_suit;

  logic        rank_ok;
  logic [5:0]  card_pos;
  logic        card_bad;
  logic [51:0] mask_next;
  logic        bad_next;
  logic [83:0] num_next;
  logic [41:0] suit_next;

  // The 21st card is stored and judged in the same edge, so the frame buses are
  // built from the storage with the current card already merged in.
  always_comb begin
    rank_ok   = (in_num >= 4'd1) && (in_num <= 4'd13);
    card_pos  = rank_ok ? {in_num - 4'd1, in_suit} : 6'd0;
    card_bad  = !rank_ok || mask[card_pos];
    mask_next = rank_ok ? (mask | (52'd1 << card_pos)) : mask;
    bad_next  = bad | card_bad;
    num_next  = frame_num;
    suit_next = frame_suit;
    num_next[{idx, 2'b00} +: 4]  = in_num;
    suit_next[{idx, 1'b0} +: 2]  = in_suit;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state         <= IDLE;
      idx           <= 5'd0;
      mask          <= 52'd0;
      bad           <= 1'b0;
      frame_num     <= 84'd0;
      frame_suit    <= 42'd0;
      in_ready      <= 1'b1;
      out_valid     <= 1'b0;
      out_err       <= 1'b0;
      out_hole_num  <= 72'd0;
      out_hole_suit <= 36'd0;
      out_pub_num   <= 12'd0;
      out_pub_suit  <= 6'd0;
    end else begin
      out_valid     <= 1'b0;
      out_err       <= 1'b0;
      out_hole_num  <= 72'd0;
      out_hole_suit <= 36'd0;
      out_pub_num   <= 12'd0;
      out_pub_suit  <= 6'd0;
      case (state)
        IDLE: begin
          in_ready <= 1'b1;
          if (in_valid) begin
            frame_num  <= num_next;
            frame_suit <= suit_next;
            mask       <= mask_next;
            bad        <= bad_next;
            idx        <= 5'd1;
            state      <= LOAD;
          end
        end

        LOAD: begin
          if (in_valid) begin
            frame_num  <= num_next;
            frame_suit <= suit_next;
            mask       <= mask_next;
            bad        <= bad_next;
            if (idx == LAST_IDX) begin
              state    <= SEND;
              in_ready <= 1'b0;
              if (bad_next) begin
                out_err <= 1'b1;
              end else begin
                out_valid     <= 1'b1;
                out_hole_num  <= num_next[71:0];
                out_hole_suit <= suit_next[35:0];
                out_pub_num   <= num_next[83:72];
                out_pub_suit  <= suit_next[41:36];
              end
            end else begin
              idx <= idx + 5'd1;
            end
          end else begin
            // A gap in the strobe abandons the partial frame.
            out_err <= 1'b1;
            state   <= IDLE;
            idx     <= 5'd0;
            mask    <= 52'd0;
            bad     <= 1'b0;
          end
        end

        SEND: begin
          state    <= IDLE;
          in_ready <= 1'b1;
          idx      <= 5'd0;
          mask     <= 52'd0;
          bad      <= 1'b0;
        end

        default: begin
          state    <= IDLE;
          in_ready <= 1'b1;
          idx      <= 5'd0;
          mask     <= 52'd0;
          bad      <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_card_dealer.sv
// Testbench for card_dealer: directed scenarios plus random deals, each checked
// against a deck-level reference model of what a correct deal frame looks like.
module tb_card_dealer;

  logic        clk;
  logic        rst_n;
  logic        in_valid;
  logic [3:0]  in_num;
  logic [1:0]  in_suit;
  logic        in_ready;
  logic        out_valid;
  logic [71:0] out_hole_num;
  logic [35:0] out_hole_suit;
  logic [11:0] out_pub_num;
  logic [5:0]  out_pub_suit;
  logic        out_err;

  int n_checks;
  int n_errors;

  logic [3:0]   fn [21];
  logic [1:0]   fs [21];
  logic [127:0] obs;
  logic         obs_ready;

  int base_n [21] = '{1, 2, 3, 13, 4, 5, 6, 7, 8, 9, 10, 12, 1, 2, 3, 4, 5, 6, 7, 8, 11};
  int base_s [21] = '{0, 0, 0, 3,  1, 1, 1, 1, 1, 1, 1,  1,  2, 2, 2, 2, 2, 2, 2, 2, 0};

  card_dealer dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .in_valid      (in_valid),
    .in_num        (in_num),
    .in_suit       (in_suit),
    .in_ready      (in_ready),
    .out_valid     (out_valid),
    .out_hole_num  (out_hole_num),
    .out_hole_suit (out_hole_suit),
    .out_pub_num   (out_pub_num),
    .out_pub_suit  (out_pub_suit),
    .out_err       (out_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Sample what the last rising edge produced, then drive this cycle's inputs.
  task automatic drive_cycle(input logic v, input logic [3:0] n, input logic [1:0] s, input logic r);
    @(negedge clk);
    obs       = {out_valid, out_err, out_hole_num, out_hole_suit, out_pub_num, out_pub_suit};
    obs_ready = in_ready;
    in_valid  = v;
    in_num    = n;
    in_suit   = s;
    rst_n     = r;
  endtask

  task automatic send_cards(input int count);
    for (int i = 0; i < count; i++) drive_cycle(1'b1, fn[i], fs[i], 1'b1);
  endtask

  task automatic load_base();
    for (int i = 0; i < 21; i++) begin
      fn[i] = 4'(base_n[i]);
      fs[i] = 2'(base_s[i]);
    end
  endtask

  // Reference: a deal is good only if every card is a real card (rank 1..13)
  // and no physical card appears twice; a good deal is laid out seat by seat.
  task automatic model_frame(output logic [127:0] exp);
    bit          seen [64];
    logic        is_bad;
    logic [71:0] hn;
    logic [35:0] hs;
    logic [11:0] pn;
    logic [5:0]  ps;
    int          key;
    is_bad = 1'b0;
    hn = '0; hs = '0; pn = '0; ps = '0;
    for (int k = 0; k < 64; k++) seen[k] = 1'b0;
    for (int i = 0; i < 21; i++) begin
      key = int'(fn[i]) * 4 + int'(fs[i]);
      if (fn[i] < 1 || fn[i] > 13 || seen[key]) is_bad = 1'b1;
      seen[key] = 1'b1;
      if (i < 18) begin
        hn[i*4 +: 4] = fn[i];
        hs[i*2 +: 2] = fs[i];
      end else begin
        pn[(i-18)*4 +: 4] = fn[i];
        ps[(i-18)*2 +: 2] = fs[i];
      end
    end
    if (is_bad) exp = {1'b0, 1'b1, 126'd0};
    else        exp = {1'b1, 1'b0, hn, hs, pn, ps};
  endtask

  task automatic test_reset();
    drive_cycle(1'b0, 4'd0, 2'd0, 1'b0);
    drive_cycle(1'b0, 4'd0, 2'd0, 1'b1);
    n_checks++;
    if (obs !== 128'd0) begin
      n_errors++;
      $display("[TB] FAIL reset_outputs: got %h expected 0", obs);
    end
    n_checks++;
    if (obs_ready !== 1'b1) begin
      n_errors++;
      $display("[TB] FAIL reset_ready: got %b expected 1", obs_ready);
    end
  endtask

  task automatic test_legal_frame();
    logic [127:0] exp;
    load_base();
    model_frame(exp);
    send_cards(21);
    drive_cycle(1'b0, 4'd0, 2'd0, 1'b1);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("[TB] FAIL legal_frame: got %h expected %h", obs, exp);
    end
    n_checks++;
    if (out_hole_num[3:0] !== 4'd1 || out_pub_num[11:8] !== 4'd11) begin
      n_errors++;
      $display("[TB] FAIL legal_corners: got p0c0=%0d pub2=%0d expected 1 and 11",
               out_hole_num[3:0], out_pub_num[11:8]);
    end
    n_checks++;
    if (obs_ready !== 1'b0) begin
      n_errors++;
      $display("[TB] FAIL send_ready: got %b expected 0", obs_ready);
    end
    drive_cycle(1'b0, 4'd0, 2'd0, 1'b1);
    n_checks++;
    if (obs !== 128'd0 || obs_ready !== 1'b1) begin
      n_errors++;
      $display("[TB] FAIL legal_after: got %h ready %b expected 0 ready 1", obs, obs_ready);
    end
  endtask

  task automatic test_duplicate();
    logic [127:0] exp;
    load_base();
    fn[10] = 4'd13;
    fs[10] = 2'd3;
    model_frame(exp);
    send_cards(21);
    drive_cycle(1'b0, 4'd0, 2'd0, 1'b1);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("[TB] FAIL duplicate: got %h expected %h", obs, exp);
    end
    drive_cycle(1'b0, 4'd0, 2'd0, 1'b1);
    n_checks++;
    if (obs !== 128'd0) begin
      n_errors++;
      $display("[TB] FAIL duplicate_after: got %h expected 0", obs);
    end
  endtask

  task automatic test_bad_rank();
    logic [127:0] exp;
    load_base();
    fn[20] = 4'd14;
    model_frame(exp);
    send_cards(21);
    drive_cycle(1'b0, 4'd0, 2'd0, 1'b1);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("[TB] FAIL bad_rank: got %h expected %h", obs, exp);
    end
    drive_cycle(1'b0, 4'd0, 2'd0, 1'b1);
    n_checks++;
    if (obs !== 128'd0) begin
      n_errors++;
      $display("[TB] FAIL bad_rank_after: got %h expected 0", obs);
    end
  endtask

  task automatic test_abort();
    logic [127:0] exp;
    load_base();
    send_cards(12);
    drive_cycle(1'b0, 4'd0, 2'd0, 1'b1);
    n_checks++;
    if (obs !== 128'd0) begin
      n_errors++;
      $display("[TB] FAIL abort_early: got %h expected 0", obs);
    end
    drive_cycle(1'b0, 4'd0, 2'd0, 1'b1);
    n_checks++;
    if (obs !== {1'b0, 1'b1, 126'd0} || obs_ready !== 1'b1) begin
      n_errors++;
      $display("[TB] FAIL abort_pulse: got %h ready %b expected err only, ready 1", obs, obs_ready);
    end
    drive_cycle(1'b0, 4'd0, 2'd0, 1'b1);
    n_checks++;
    if (obs !== 128'd0) begin
      n_errors++;
      $display("[TB] FAIL abort_after: got %h expected 0", obs);
    end
    model_frame(exp);
    send_cards(21);
    drive_cycle(1'b0, 4'd0, 2'd0, 1'b1);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("[TB] FAIL abort_recover: got %h expected %h", obs, exp);
    end
  endtask

  task automatic test_back_to_back();
    logic [127:0] exp1;
    logic [127:0] exp2;
    load_base();
    model_frame(exp1);
    send_cards(21);
    drive_cycle(1'b1, 4'd5, 2'd3, 1'b1);
    n_checks++;
    if (obs !== exp1 || obs_ready !== 1'b0) begin
      n_errors++;
      $display("[TB] FAIL overrun_first: got %h ready %b expected %h ready 0", obs, obs_ready, exp1);
    end
    for (int i = 0; i < 21; i++) begin
      fn[i] = 4'(base_n[20 - i]);
      fs[i] = 2'(base_s[20 - i]);
    end
    model_frame(exp2);
    drive_cycle(1'b1, fn[0], fs[0], 1'b1);
    n_checks++;
    if (obs !== 128'd0 || obs_ready !== 1'b1) begin
      n_errors++;
      $display("[TB] FAIL overrun_gap: got %h ready %b expected 0 ready 1", obs, obs_ready);
    end
    for (int i = 1; i < 21; i++) drive_cycle(1'b1, fn[i], fs[i], 1'b1);
    drive_cycle(1'b0, 4'd0, 2'd0, 1'b1);
    n_checks++;
    if (obs !== exp2) begin
      n_errors++;
      $display("[TB] FAIL overrun_second: got %h expected %h", obs, exp2);
    end
    drive_cycle(1'b0, 4'd0, 2'd0, 1'b1);
  endtask

  task automatic test_reset_mid();
    logic [127:0] exp;
    load_base();
    send_cards(15);
    drive_cycle(1'b1, fn[15], fs[15], 1'b0);
    drive_cycle(1'b0, 4'd0, 2'd0, 1'b1);
    n_checks++;
    if (obs !== 128'd0 || obs_ready !== 1'b1) begin
      n_errors++;
      $display("[TB] FAIL reset_mid: got %h ready %b expected 0 ready 1", obs, obs_ready);
    end
    drive_cycle(1'b0, 4'd0, 2'd0, 1'b1);
    n_checks++;
    if (obs !== 128'd0) begin
      n_errors++;
      $display("[TB] FAIL reset_mid_quiet: got %h expected 0", obs);
    end
    model_frame(exp);
    send_cards(21);
    drive_cycle(1'b0, 4'd0, 2'd0, 1'b1);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("[TB] FAIL reset_mid_fresh: got %h expected %h", obs, exp);
    end
    drive_cycle(1'b0, 4'd0, 2'd0, 1'b1);
  endtask

  task automatic test_random();
    int deck [52];
    int j;
    int t;
    int mode;
    logic [127:0] exp;
    for (int f = 0; f < 24; f++) begin
      for (int k = 0; k < 52; k++) deck[k] = k;
      for (int k = 51; k > 0; k--) begin
        j = int'($urandom_range(0, k));
        t = deck[k];
        deck[k] = deck[j];
        deck[j] = t;
      end
      for (int i = 0; i < 21; i++) begin
        fn[i] = 4'(deck[i] / 4 + 1);
        fs[i] = 2'(deck[i] % 4);
      end
      mode = int'($urandom_range(0, 3));
      if (mode == 0) begin
        j = int'($urandom_range(1, 20));
        t = int'($urandom_range(0, j - 1));
        fn[j] = fn[t];
        fs[j] = fs[t];
      end else if (mode == 1) begin
        j = int'($urandom_range(0, 20));
        fn[j] = ($urandom_range(0, 1) == 0) ? 4'd0 : 4'(14 + $urandom_range(0, 1));
      end
      model_frame(exp);
      send_cards(21);
      drive_cycle(1'($urandom_range(0, 1)), 4'($urandom_range(0, 15)), 2'($urandom_range(0, 3)), 1'b1);
      n_checks++;
      if (obs !== exp) begin
        n_errors++;
        $display("[TB] FAIL random_frame%0d: got %h expected %h", f, obs, exp);
      end
      drive_cycle(1'b0, 4'd0, 2'd0, 1'b1);
      n_checks++;
      if (obs !== 128'd0 || obs_ready !== 1'b1) begin
        n_errors++;
        $display("[TB] FAIL random_after%0d: got %h ready %b expected 0 ready 1", f, obs, obs_ready);
      end
    end
  endtask

  initial begin
    n_checks = 0;
    n_errors = 0;
    rst_n    = 1'b0;
    in_valid = 1'b0;
    in_num   = 4'd0;
    in_suit  = 2'd0;
    test_reset();
    test_legal_frame();
    test_duplicate();
    test_bad_rank();
    test_abort();
    test_back_to_back();
    test_reset_mid();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/card_dealer.md
CARD_DEALER -- requirements
Module: card_dealer

Interface
REQ-001 Parameters: none; all widths fixed for 9 players, 2 hole cards each, 3 public cards.
REQ-002 clk  input  1  single clock; all state changes on rising edge.
REQ-003 rst_n  input  1  reset, synchronous, active-low.
REQ-004 in_valid  input  1  serial card strobe; one card per cycle while high.
REQ-005 in_num  input  4  card rank, legal 1..13.
REQ-006 in_suit  input  2  card suit 0..3.
REQ-007 in_ready  output  1  high when a card offered this cycle is accepted.
REQ-008 out_valid  output  1  one-cycle pulse: packed deal frame valid.
REQ-009 out_hole_num  output  72  hole ranks, player p card c at bits [(2p+c)*4 +: 4].
REQ-010 out_hole_suit  output  36  hole suits, player p card c at bits [(2p+c)*2 +: 2].
REQ-011 out_pub_num  output  12  public ranks, public card k at bits [k*4 +: 4].
REQ-012 out_pub_suit  output  6  public suits, public card k at bits [k*2 +: 2].
REQ-013 out_err  output  1  one-cycle pulse: frame rejected.

Function
REQ-014 Frame = 21 accepted cards in order: P0C0, P0C1, P1C0, ... P8C1, then PUB0, PUB1, PUB2.
REQ-015 States IDLE, LOAD, SEND; 5-bit card counter idx 0..20; 52-bit used-card mask indexed (in_num-1)*4+in_suit.
REQ-016 in_ready = 1 in IDLE and LOAD, 0 in SEND; cards offered in SEND are ignored, not counted, not flagged.
REQ-017 IDLE: in_valid=1 accepts card at idx 0, goes LOAD, idx<=1; in_valid=0 stays IDLE.
REQ-018 LOAD: in_valid=1 stores card at idx; idx=20 -> SEND, else idx+1.
REQ-019 LOAD: in_valid=0 before idx 21 reached = abort; out_err pulses next cycle, state IDLE, idx and mask cleared, no out_valid.
REQ-020 Card invalid if in_num=0 or in_num>13 or mask bit already set; invalid card sets sticky bad flag, frame continues to 21 cards.
REQ-021 SEND (exactly one cycle): bad=0 -> out_valid=1 with packed buses; bad=1 -> out_err=1, buses 0; then IDLE, idx, mask, bad cleared.
REQ-022 Latency: out_valid/out_err asserted the cycle after the 21st card is accepted.
REQ-023 out_valid and out_err never high together.
REQ-024 All four data buses SHALL be 0 whenever out_valid=0.
REQ-025 Earliest next frame: in_valid sampled in the cycle after SEND (IDLE); back-to-back frames need one idle/ignored cycle.
REQ-026 Mask check uses card index of the current cycle against mask before the update, so duplicate within same frame always detected; mask not carried across frames.

Reset
REQ-027 rst_n=0 at a rising edge: state IDLE, idx 0, mask 0, bad 0, out_valid 0, out_err 0, all buses 0, in_ready 1 the following cycle.
REQ-028 Reset mid-LOAD or during SEND discards the partial frame with no out_valid or out_err pulse.
REQ-029 Outputs are registered; no output depends combinationally on in_num/in_suit.

Verification
REQ-030 21 distinct legal cards, P0C0=(1,0) ... PUB2=(11,0), contiguous in_valid -> out_valid pulse 1 cycle after 21st card, out_hole_num[3:0]=1, out_pub_num[11:8]=11, out_err=0.
REQ-031 Card 10 duplicates card 3 (13,3) -> after 21st card out_err=1 for one cycle, out_valid=0, buses 0.
REQ-032 Card with in_num=14 at idx 20 (PUB2) -> out_err pulse, no out_valid.
REQ-033 in_valid drops after 12 cards -> out_err next cycle, state IDLE; following legal 21-card frame yields out_valid with correct packing.
REQ-034 in_valid held high for 22 cycles -> 22nd card ignored (in_ready=0 in SEND), out_valid once; new frame accepted from 23rd cycle.
REQ-035 rst_n=0 at card 15 -> no output pulse; outputs 0; fresh 21-card frame afterwards produces out_valid with no stale mask bits.
